// File: rtl/console_uart_tx.sv
// console_uart_tx: memory-mapped console character FIFO feeding an 8N1 UART transmitter
module console_uart_tx #(
    parameter int          CLKDIV     = 16,
    parameter int          FIFO_DEPTH = 16,
    parameter logic [31:0] ADDR_DATA  = 32'h1000_0000,
    parameter logic [31:0] ADDR_STAT  = 32'h1000_0004
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        mem_valid,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    input  logic [3:0]  mem_wstrb,
    output logic        mem_ready,
    output logic [31:0] mem_rdata,
    output logic        sel,
    output logic        uart_tx
);
    localparam int AW = $clog2(FIFO_DEPTH);
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
    state_t        state;
    logic [7:0]    fifo [FIFO_DEPTH];
    logic [AW-1:0] rd_ptr, wr_ptr;
    logic [8:0]    count;
    logic [15:0]   div;
    logic [2:0]    bit_cnt;
    logic [7:0]    shift;
    logic          rst_hold;
    logic          is_data, accept, push_req, full, empty, push, pop, bit_end, idle;
    logic [31:0]   stat;
    logic          unused_ok;

    assign is_data   = mem_addr == ADDR_DATA;
    assign sel       = mem_valid && (is_data || mem_addr == ADDR_STAT);
    // rst_hold masks the first cycle after reset release
    assign accept    = sel && !mem_ready && !rst_hold;
    assign full      = count == 9'(FIFO_DEPTH);
    assign empty     = count == 9'd0;
    assign push_req  = accept && is_data && mem_wstrb[0];
    assign push      = push_req && !full;
    assign bit_end   = div == 16'(CLKDIV - 1);
    assign pop       = !empty && (state == IDLE || (state == STOP && bit_end));
    assign idle      = state == IDLE && empty;
    assign stat      = {16'b0, count[7:0], 5'b0, idle, empty, full};
    assign unused_ok = ^mem_wdata[31:8];

    always_ff @(posedge clk)
        if (push) fifo[wr_ptr] <= mem_wdata[7:0];

    always_ff @(posedge clk) begin
        if (!resetn) begin
            mem_ready <= 1'b0;
            mem_rdata <= '0;
            rst_hold  <= 1'b1;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
        end else begin
            rst_hold  <= 1'b0;
            mem_ready <= accept && !(push_req && full);
            mem_rdata <= (accept && !is_data && mem_wstrb == 4'b0000) ? stat : '0;
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop) rd_ptr <= rd_ptr + AW'(1);
            count     <= count + 9'(push) - 9'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state   <= IDLE;
            div     <= '0;
            bit_cnt <= '0;
            shift   <= '0;
            uart_tx <= 1'b1;
        end else if (pop) begin
            state   <= START;
            div     <= '0;
            shift   <= fifo[rd_ptr];
            uart_tx <= 1'b0;
        end else if (state != IDLE) begin
            div <= bit_end ? 16'd0 : div + 16'd1;
            if (bit_end) begin
                if (state == START || (state == DATA && bit_cnt != 3'd7)) begin
                    state   <= DATA;
                    uart_tx <= shift[0];
                    shift   <= shift >> 1;
                    bit_cnt <= state == START ? 3'd0 : bit_cnt + 3'd1;
                end else if (state == DATA) begin
                    state   <= STOP;
                    uart_tx <= 1'b1;
                end else begin
                    state <= IDLE;
                end
            end
        end
    end
endmodule
